mem_access_unit: RTL and testbench

Parametrised memory-access (MA) pipeline stage for the SimpleRisc core, sitting between the execute stage and the register-writeback stage. It replaces direct combinational memory poking with a registered stage:
- valid/ready handshakes on both the pipeline and data-memory sides;
- byte, halfword and word loads and stores, with sign/zero extension on loads;
- misalignment detection;
- a bus-timeout counter for loads.

---
 rtl/ma_pkg.sv | 72 +++++++
 rtl/ma_load_align.sv | 15 +
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
// Shared encodings and lane helpers for the SimpleRisc memory-access stage.
// The helpers are pure functions so the cache path can reuse them unchanged.
package ma_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_OUT  = 2'd3
    } ma_state_e;

    // Encoding 3 is an alias for a word access.
    function automatic logic [1:0] f_norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] op2);
        logic [31:0] wd;
        wd = op2;
        case (size)
            SZ_BYTE: wd = {4{op2[7:0]}};
            SZ_HALF: wd = {2{op2[15:0]}};
            default: wd = op2;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] f_load_extract(input logic [31:0] rdata,
                                                   input logic [1:0]  addr_lo,
                                                   input logic [1:0]  size,
                                                   input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = rdata[{addr_lo, 3'b000} +: 8];
        h   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        res = rdata;
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ma_load_align.sv
// Combinational load-lane selector: picks the addressed byte/half/word from a
// 32-bit read beat and zero- or sign-extends it.
module ma_load_align
    import ma_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_result
);

    assign o_result = f_load_extract(i_rdata, i_addr_lo, i_size, i_signed);

endmodule

// File: rtl/mem_access_unit.sv
// Registered memory-access stage between execute and writeback: issues aligned
// data-memory requests, aligns load data, flags misalignment and load timeouts.
module mem_access_unit
    import ma_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int RD_W        = 4,
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_op2,
    input  logic              ex_is_ld,
    input  logic              ex_is_st,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [RD_W-1:0]   ex_rd,
    output logic              mem_req,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_result,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_we,
    output logic              wb_err,
    output ma_state_e         dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a producer holding valid keeps its payload stable until then.

    ma_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_alu;
    logic [1:0]       r_size;
    logic             r_signed;

    logic        w_accept;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_mem;
    logic        w_mis;
    logic [1:0]  w_size;
    logic [1:0]  w_addr_lo;
    logic [31:0] w_load_data;

    // wb_valid is high exactly in OUT, so the stage may refill as it drains.
    assign ex_ready  = (r_state == ST_IDLE) || ((r_state == ST_OUT) && wb_ready);
    assign w_accept  = ex_valid && ex_ready;
    assign w_size    = f_norm_size(ex_size);
    assign w_addr_lo = ex_alu_result[1:0];
    assign w_is_ld   = ex_is_ld;
    assign w_is_st   = ex_is_st && !ex_is_ld;
    assign w_is_mem  = w_is_ld || w_is_st;
    assign w_mis     = w_is_mem && f_misaligned(w_size, w_addr_lo);
    assign dbg_state = r_state;

    ma_load_align u_load_align (
        .i_rdata   (mem_rdata),
        .i_addr_lo (r_alu[1:0]),
        .i_size    (r_size),
        .i_signed  (r_signed),
        .o_result  (w_load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_alu     <= '0;
            r_size    <= SZ_BYTE;
            r_signed  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            wb_valid  <= 1'b0;
            wb_result <= '0;
            wb_rd     <= '0;
            wb_we     <= 1'b0;
            wb_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OUT: begin
                    if (w_accept) begin
                        r_alu    <= ex_alu_result;
                        r_size   <= w_size;
                        r_signed <= ex_signed;
                        wb_rd    <= ex_rd;
                        if (!w_is_mem || w_mis) begin
                            r_state   <= ST_OUT;
                            wb_valid  <= 1'b1;
                            wb_result <= ex_alu_result;
                            wb_we     <= !w_mis;
                            wb_err    <= w_mis;
                        end else begin
                            r_state   <= ST_REQ;
                            wb_valid  <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= w_is_st;
                            mem_addr  <= {ex_alu_result[ADDR_W-1:2], 2'b00};
                            mem_wdata <= w_is_st ? f_store_data(w_size, ex_op2) : 32'h0;
                            mem_be    <= f_byte_en(w_size, w_addr_lo);
                        end
                    end else if ((r_state == ST_OUT) && wb_ready) begin
                        r_state  <= ST_IDLE;
                        wb_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (mem_we) begin
                            r_state   <= ST_OUT;
                            wb_valid  <= 1'b1;
                            wb_result <= r_alu;
                            wb_we     <= 1'b0;
                            wb_err    <= 1'b0;
                        end else begin
                            r_state <= ST_RESP;
                            r_cnt   <= CNT_W'(TIMEOUT_CYC);
                        end
                    end
                end
                ST_RESP: begin
                    // Data arriving in the final counted cycle beats the timeout.
                    if (mem_rvalid) begin
                        r_state   <= ST_OUT;
                        r_cnt     <= '0;
                        wb_valid  <= 1'b1;
                        wb_result <= w_load_data;
                        wb_we     <= 1'b1;
                        wb_err    <= 1'b0;
                    end else if (r_cnt <= CNT_W'(1)) begin
                        r_state   <= ST_OUT;
                        r_cnt     <= '0;
                        wb_valid  <= 1'b1;
                        wb_result <= '0;
                        wb_we     <= 1'b0;
                        wb_err    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: expected writeback and memory-request
// beats are queued at issue time and checked by an independent monitor.
module tb_mem_access_unit;
    import ma_pkg::*;

    localparam int ADDR_W = 32;
    localparam int RD_W   = 4;
    localparam int TMO    = 4;

    logic              clk;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [31:0]       ex_alu_result;
    logic [31:0]       ex_op2;
    logic              ex_is_ld;
    logic              ex_is_st;
    logic [1:0]        ex_size;
    logic              ex_signed;
    logic [RD_W-1:0]   ex_rd;
    logic              mem_req;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_result;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_we;
    logic              wb_err;
    ma_state_e         dbg_state;

    mem_access_unit #(.ADDR_W(ADDR_W), .RD_W(RD_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_result(ex_alu_result),
        .ex_op2(ex_op2), .ex_is_ld(ex_is_ld), .ex_is_st(ex_is_st), .ex_size(ex_size),
        .ex_signed(ex_signed), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_result(wb_result), .wb_rd(wb_rd),
        .wb_we(wb_we), .wb_err(wb_err), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {result, rd, we, err}
    logic [37:0] exp_wb_q[$];
    // {we, addr, wdata, be}
    logic [68:0] exp_mem_q[$];

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [68:0] mem_snap;
    logic [68:0] mem_cur;
    bit          mem_active = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mem_active = 1'b0;
        end else begin
            if (wb_valid && wb_ready) begin
                if (exp_wb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected: got 0x%0h expected no writeback", wb_result);
                end else begin
                    check("wb_beat", {31'h0, wb_result, wb_rd, wb_we, wb_err}, {31'h0, exp_wb_q.pop_front()});
                end
            end
            mem_cur = {mem_we, mem_addr, mem_wdata, mem_be};
            if (mem_req) begin
                if (!mem_active) begin
                    if (exp_mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_unexpected: got 0x%0h expected no request", mem_cur);
                    end else begin
                        check("mem_req_beat", mem_cur, exp_mem_q.pop_front());
                    end
                    mem_snap = mem_cur;
                end else begin
                    check("mem_hold", mem_cur, mem_snap);
                end
                mem_active = !mem_ready;
            end else begin
                mem_active = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns one cycle after the accepting edge.
    task automatic issue(input logic [31:0] alu, input logic [31:0] op2, input logic ld,
                         input logic st, input logic [1:0] size, input logic sgn,
                         input logic [3:0] rd);
        int n;
        ex_alu_result = alu;
        ex_op2        = op2;
        ex_is_ld      = ld;
        ex_is_st      = st;
        ex_size       = size;
        ex_signed     = sgn;
        ex_rd         = rd;
        ex_valid      = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ex_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
    endtask

    // Holds mem_ready low for 'delay' cycles, then completes one handshake.
    task automatic mem_handshake(input int delay);
        step(delay);
        mem_ready = 1'b1;
        step(1);
        mem_ready = 1'b0;
    endtask

    task automatic load_resp(input int delay, input logic [31:0] data);
        step(delay);
        mem_rdata  = data;
        mem_rvalid = 1'b1;
        step(1);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic expect_wb_now(input string name);
        @(negedge clk);
        check(name, {68'h0, wb_valid}, 69'h1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_op2 = '0; ex_is_ld = 1'b0;
        ex_is_st = 1'b0; ex_size = 2'd0; ex_signed = 1'b0; ex_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_async_wb_valid", {68'h0, wb_valid}, 69'h0);
        check("rst_async_mem_req", {68'h0, mem_req}, 69'h0);
        step(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ex_ready", {68'h0, ex_ready}, 69'h1);
        check("rst_state", {67'h0, dbg_state}, {67'h0, ST_IDLE});
        check("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, 70'h0);
        check("rst_wb", {wb_valid, wb_result, wb_rd, wb_we, wb_err}, 39'h0);
        @(posedge clk);
        #1;

        // pass-through
        exp_wb_q.push_back({32'h1234_5678, 4'd3, 1'b1, 1'b0});
        issue(32'h1234_5678, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0, 4'd3);
        expect_wb_now("pass_lat");

        // byte store with delayed mem_ready
        exp_mem_q.push_back({1'b1, 32'h0000_0100, 32'hABAB_ABAB, 4'b1000});
        exp_wb_q.push_back({32'h0000_0103, 4'd1, 1'b0, 1'b0});
        issue(32'h0000_0103, 32'h0000_00AB, 1'b0, 1'b1, SZ_BYTE, 1'b0, 4'd1);
        mem_handshake(3);
        expect_wb_now("st_byte_lat");

        // half store, upper lane; word store via size 3
        exp_mem_q.push_back({1'b1, 32'h0000_0204, 32'hBEEF_BEEF, 4'b1100});
        exp_wb_q.push_back({32'h0000_0206, 4'd2, 1'b0, 1'b0});
        issue(32'h0000_0206, 32'h1234_BEEF, 1'b0, 1'b1, SZ_HALF, 1'b0, 4'd2);
        mem_handshake(0);
        step(1);
        exp_mem_q.push_back({1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111});
        exp_wb_q.push_back({32'h0000_0040, 4'd4, 1'b0, 1'b0});
        issue(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd3, 1'b0, 4'd4);
        mem_handshake(1);
        step(1);

        // signed / unsigned half loads, minimum latency
        exp_mem_q.push_back({1'b0, 32'h0000_0200, 32'h0, 4'b1100});
        exp_wb_q.push_back({32'hFFFF_8001, 4'd5, 1'b1, 1'b0});
        issue(32'h0000_0202, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b1, 4'd5);
        mem_handshake(0);
        load_resp(0, 32'h8001_0000);
        expect_wb_now("ld_min_lat");
        exp_mem_q.push_back({1'b0, 32'h0000_0200, 32'h0, 4'b1100});
        exp_wb_q.push_back({32'h0000_8001, 4'd6, 1'b1, 1'b0});
        issue(32'h0000_0202, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b0, 4'd6);
        mem_handshake(2);
        load_resp(1, 32'h8001_0000);
        step(1);

        // signed byte lane 1; word load with both ld and st set
        exp_mem_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b0010});
        exp_wb_q.push_back({32'hFFFF_FF80, 4'd7, 1'b1, 1'b0});
        issue(32'h0000_0101, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b1, 4'd7);
        mem_handshake(0);
        load_resp(0, 32'h1122_80FF);
        step(1);
        exp_mem_q.push_back({1'b0, 32'h0000_0010, 32'h0, 4'b1111});
        exp_wb_q.push_back({32'hCAFE_F00D, 4'd8, 1'b1, 1'b0});
        issue(32'h0000_0010, 32'h5555_5555, 1'b1, 1'b1, SZ_WORD, 1'b1, 4'd8);
        mem_handshake(0);
        load_resp(2, 32'hCAFE_F00D);
        step(1);

        // misaligned word load and half store: no memory traffic
        exp_wb_q.push_back({32'h0000_0302, 4'd9, 1'b0, 1'b1});
        issue(32'h0000_0302, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 4'd9);
        expect_wb_now("mis_word_lat");
        exp_wb_q.push_back({32'h0000_0305, 4'd10, 1'b0, 1'b1});
        issue(32'h0000_0305, 32'h1111, 1'b0, 1'b1, SZ_HALF, 1'b0, 4'd10);
        step(1);

        // stray rvalid while idle is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step(2);
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // timeout: wb_valid TMO+1 cycles after the handshake
        exp_mem_q.push_back({1'b0, 32'h0000_0400, 32'h0, 4'b1111});
        exp_wb_q.push_back({32'h0, 4'd11, 1'b0, 1'b1});
        issue(32'h0000_0400, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 4'd11);
        mem_handshake(0);
        n = 1;
        @(negedge clk);
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_lat", 69'(n), 69'(TMO + 1));
        @(posedge clk);
        #1;

        // data arriving in the last counted cycle wins
        exp_mem_q.push_back({1'b0, 32'h0000_0404, 32'h0, 4'b1111});
        exp_wb_q.push_back({32'h600D_DA7A, 4'd12, 1'b1, 1'b0});
        issue(32'h0000_0404, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 4'd12);
        mem_handshake(0);
        load_resp(TMO - 1, 32'h600D_DA7A);
        expect_wb_now("data_wins_lat");

        // back-to-back pass-through
        for (int i = 0; i < 4; i++) begin
            ex_alu_result = 32'h0000_1000 + 32'(i);
            ex_is_ld = 1'b0; ex_is_st = 1'b0; ex_rd = 4'(i);
            exp_wb_q.push_back({32'h0000_1000 + 32'(i), 4'(i), 1'b1, 1'b0});
            ex_valid = 1'b1;
            @(negedge clk);
            check("burst_ready", {68'h0, ex_ready}, 69'h1);
            @(posedge clk);
            #1;
        end
        ex_valid = 1'b0;
        step(1);

        // back-pressure
        wb_ready = 1'b0;
        exp_wb_q.push_back({32'h0000_0BAD, 4'd13, 1'b1, 1'b0});
        issue(32'h0000_0BAD, 32'h0, 1'b0, 1'b0, SZ_WORD, 1'b0, 4'd13);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold", {67'h0, wb_valid, ex_ready}, 69'b10);
            @(posedge clk);
            #1;
        end
        wb_ready = 1'b1;
        step(2);

        // reset while waiting for load data, then a clean load
        exp_mem_q.push_back({1'b0, 32'h0000_0500, 32'h0, 4'b1111});
        issue(32'h0000_0500, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0, 4'd14);
        mem_handshake(0);
        @(negedge clk);
        check("pre_rst_state", {67'h0, dbg_state}, {67'h0, ST_RESP});
        #1 rst = 1'b1;
        #1;
        check("rst_mid_mem", {mem_req, mem_we, mem_addr, mem_wdata, mem_be}, 70'h0);
        check("rst_mid_wb", {wb_valid, wb_result, wb_rd, wb_we, wb_err}, 39'h0);
        step(1);
        rst = 1'b0;
        step(1);
        exp_mem_q.push_back({1'b0, 32'h0000_0504, 32'h0, 4'b0001});
        exp_wb_q.push_back({32'h0000_00F0, 4'd15, 1'b1, 1'b0});
        issue(32'h0000_0504, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b0, 4'd15);
        mem_handshake(1);
        load_resp(0, 32'h1234_56F0);
        expect_wb_now("post_rst_ld_lat");

        n = 0;
        while ((exp_wb_q.size() != 0 || exp_mem_q.size() != 0) && n < 20) begin
            step(1);
            n++;
        end
        check("wb_queue_drained", 69'(exp_wb_q.size()), 69'h0);
        check("mem_queue_drained", 69'(exp_mem_q.size()), 69'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
